pixel_gen_multi: RTL and testbench

- Parametrised successor to the single-bird, three-pipe pixel renderer in the Flappy VGA path.
- Renders, per pixel, in strict priority order: bird, then N pipe pairs, then ground strip, then background.
- Fixed two-stage pipeline; sits between the VGA sync counter and the DAC pins.
- Also produces a per-frame bird/obstacle collision flag for the game FSM.

---
 rtl/pixel_gen_multi_if.sv | 29 ++
 rtl/pixel_gen_multi.sv | 165 ++++++++++++++++
 tb/tb_pixel_gen_multi.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_gen_multi_if.sv
// Pixel-path bundle for pixel_gen_multi: sync-counter pixel inputs, game-state sprite positions, colour and collision outputs.
// The master side drives the pixel and game inputs. The slave side is the renderer.
interface pixel_gen_multi_if #(
    parameter int NUM_PIPES = 3
);
    logic [9:0]              pixel_x;
    logic [9:0]              pixel_y;
    logic                    video_on;
    logic [9:0]              bird_x;
    logic [9:0]              bird_y;
    logic [10*NUM_PIPES-1:0] pipe_x;
    logic [10*NUM_PIPES-1:0] pipe_gap_y;
    logic [NUM_PIPES-1:0]    pipe_en;
    logic [3:0]              red;
    logic [3:0]              green;
    logic [3:0]              blue;
    logic                    collision;
    logic                    frame_pulse;

    modport master (
        output pixel_x, pixel_y, video_on, bird_x, bird_y, pipe_x, pipe_gap_y, pipe_en,
        input  red, green, blue, collision, frame_pulse
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, bird_x, bird_y, pipe_x, pipe_gap_y, pipe_en,
        output red, green, blue, collision, frame_pulse
    );
endinterface

// File: rtl/pixel_gen_multi.sv
// Two-stage bird / N-pipe / ground pixel renderer with a per-frame collision flag; 2-clock latency, no backpressure.
// Optional COLLISION_FLASH_EN adds a frame counter that blinks the bird white while a collision is reported.
module pixel_gen_multi #(
    parameter int NUM_PIPES = 3,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 80,
    parameter int BIRD_W    = 20,
    parameter int BIRD_H    = 20,
    parameter int SCREEN_H  = 480,
    parameter int GROUND_Y  = 440
) (
    input  logic              clk_div,
    input  logic              start,
    pixel_gen_multi_if.slave  vif
);

    localparam logic [10:0] PIPE_W_L   = 11'(PIPE_W);
    localparam logic [10:0] GAP_H_L    = 11'(GAP_H);
    localparam logic [10:0] BIRD_W_L   = 11'(BIRD_W);
    localparam logic [10:0] BIRD_H_L   = 11'(BIRD_H);
    localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);
    localparam logic [10:0] GROUND_Y_L = 11'(GROUND_Y);

    localparam logic [11:0] RGB_BIRD   = 12'hF00;
    localparam logic [11:0] RGB_PIPE   = 12'h0F0;
    localparam logic [11:0] RGB_GROUND = 12'h840;
    localparam logic [11:0] RGB_BLACK  = 12'h000;

    // Edges are widened to 11 bits so right/bottom edges never wrap past 1023.
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] bird_l;
    logic [10:0] bird_r;
    logic [10:0] bird_t;
    logic [10:0] bird_b;

    assign x_w    = {1'b0, vif.pixel_x};
    assign y_w    = {1'b0, vif.pixel_y};
    assign bird_l = {1'b0, vif.bird_x};
    assign bird_t = {1'b0, vif.bird_y};
    assign bird_r = bird_l + BIRD_W_L;
    assign bird_b = bird_t + BIRD_H_L;

    logic [NUM_PIPES-1:0] chan_hit;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_chan
        logic [10:0] pipe_l;
        logic [10:0] pipe_r;
        logic [10:0] gap_t;
        logic [10:0] gap_b;
        logic        in_cols;
        logic        in_upper;
        logic        in_lower;

        assign pipe_l   = {1'b0, vif.pipe_x[10*i +: 10]};
        assign pipe_r   = pipe_l + PIPE_W_L;
        assign gap_t    = {1'b0, vif.pipe_gap_y[10*i +: 10]};
        assign gap_b    = gap_t + GAP_H_L;
        assign in_cols  = (x_w >= pipe_l) && (x_w < pipe_r);
        assign in_upper = (y_w < gap_t);
        assign in_lower = (y_w >= gap_b) && (y_w < SCREEN_H_L);
        assign chan_hit[i] = in_cols && (in_upper || in_lower);
    end

    // Stage 1: per-pixel hit flags.
    logic bird_hit_d,   bird_hit_q;
    logic pipe_hit_d,   pipe_hit_q;
    logic ground_hit_d, ground_hit_q;
    logic vid_d,        vid_q;
    logic sof_d,        sof_q;

    always_comb begin
        bird_hit_d   = (x_w >= bird_l) && (x_w < bird_r) &&
                       (y_w >= bird_t) && (y_w < bird_b);
        pipe_hit_d   = |(chan_hit & vif.pipe_en);
        ground_hit_d = (y_w >= GROUND_Y_L) && (y_w < SCREEN_H_L);
        vid_d        = vif.video_on;
        sof_d        = (vif.pixel_x == 10'd0) && (vif.pixel_y == 10'd0);
    end

    // Stage 2: colour select and per-frame collision accumulation.
    logic [11:0] rgb_d,         rgb_q;
    logic        acc_d,         acc_q;
    logic        collision_d,   collision_q;
    logic        frame_pulse_d, frame_pulse_q;
    logic [11:0] bird_rgb;
    logic        hit_now;

`ifdef COLLISION_FLASH_EN
    logic [4:0] frame_cnt_d, frame_cnt_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (sof_q) begin
            frame_cnt_d = frame_cnt_q + 5'd1;
        end
        bird_rgb = (collision_q && frame_cnt_q[3]) ? 12'hFFF : RGB_BIRD;
    end

    always_ff @(posedge clk_div) begin
        if (start) begin
            frame_cnt_q <= 5'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign bird_rgb = RGB_BIRD;
`endif

    always_comb begin
        hit_now       = vid_q && bird_hit_q && (pipe_hit_q || ground_hit_q);
        acc_d         = acc_q || hit_now;
        collision_d   = collision_q;
        frame_pulse_d = 1'b0;
        // A hit on the sof pixel itself still belongs to the frame that is closing.
        if (sof_q) begin
            collision_d   = acc_q || hit_now;
            frame_pulse_d = 1'b1;
            acc_d         = 1'b0;
        end

        rgb_d = RGB_BLACK;
        if (!vid_q) begin
            rgb_d = RGB_BLACK;
        end else if (bird_hit_q) begin
            rgb_d = bird_rgb;
        end else if (pipe_hit_q) begin
            rgb_d = RGB_PIPE;
        end else if (ground_hit_q) begin
            rgb_d = RGB_GROUND;
        end
    end

    always_ff @(posedge clk_div) begin
        if (start) begin
            bird_hit_q    <= 1'b0;
            pipe_hit_q    <= 1'b0;
            ground_hit_q  <= 1'b0;
            vid_q         <= 1'b0;
            sof_q         <= 1'b0;
            rgb_q         <= 12'h000;
            acc_q         <= 1'b0;
            collision_q   <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            bird_hit_q    <= bird_hit_d;
            pipe_hit_q    <= pipe_hit_d;
            ground_hit_q  <= ground_hit_d;
            vid_q         <= vid_d;
            sof_q         <= sof_d;
            rgb_q         <= rgb_d;
            acc_q         <= acc_d;
            collision_q   <= collision_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign vif.red         = rgb_q[11:8];
    assign vif.green       = rgb_q[7:4];
    assign vif.blue        = rgb_q[3:0];
    assign vif.collision   = collision_q;
    assign vif.frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_pixel_gen_multi.sv
// Testbench for pixel_gen_multi (5 channels): directed geometry/priority/collision steps, then random pixels against a frame-level model.
// Expectations for the optional COLLISION_FLASH_EN blink follow the same macro.
module tb_pixel_gen_multi;

    localparam int NP       = 5;
    localparam int PIPE_W   = 40;
    localparam int GAP_H    = 80;
    localparam int BIRD_W   = 20;
    localparam int BIRD_H   = 20;
    localparam int SCREEN_H = 480;
    localparam int GROUND_Y = 440;

    logic clk_div = 1'b0;
    logic start   = 1'b1;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    always #5 clk_div = ~clk_div;

    pixel_gen_multi_if #(.NUM_PIPES(NP)) pif ();

    pixel_gen_multi #(
        .NUM_PIPES(NP), .PIPE_W(PIPE_W), .GAP_H(GAP_H), .BIRD_W(BIRD_W),
        .BIRD_H(BIRD_H), .SCREEN_H(SCREEN_H), .GROUND_Y(GROUND_Y)
    ) dut (
        .clk_div (clk_div),
        .start   (start),
        .vif     (pif)
    );

    // Reference model state: what the first stage holds, and what the outputs should show.
    bit          m_vid, m_bird, m_pipe, m_gnd, m_sof;
    logic [11:0] m_rgb  = 12'h000;
    bit          m_coll = 1'b0;
    bit          m_fp   = 1'b0;
    bit          m_acc  = 1'b0;
    int          m_frames = 0;

    function automatic bit in_span(int v, int lo, int len);
        return (v >= lo) && (v < lo + len);
    endfunction

    task automatic model_tick();
        int          x, y, px, gy;
        logic [11:0] bird_c;
        if (start) begin
            {m_vid, m_bird, m_pipe, m_gnd, m_sof} = '0;
            m_rgb = 12'h000; m_coll = 0; m_fp = 0; m_acc = 0; m_frames = 0;
        end else begin
            bird_c = 12'hF00;
`ifdef COLLISION_FLASH_EN
            if (m_coll && ((m_frames % 16) >= 8)) bird_c = 12'hFFF;
`endif
            if (!m_vid)      m_rgb = 12'h000;
            else if (m_bird) m_rgb = bird_c;
            else if (m_pipe) m_rgb = 12'h0F0;
            else if (m_gnd)  m_rgb = 12'h840;
            else             m_rgb = 12'h000;
            if (m_vid && m_bird && (m_pipe || m_gnd)) m_acc = 1;
            m_fp = m_sof;
            if (m_sof) begin
                m_coll = m_acc;
                m_acc = 0;
                m_frames = (m_frames + 1) % 32;
            end
            x = int'(pif.pixel_x);
            y = int'(pif.pixel_y);
            m_vid  = pif.video_on;
            m_sof  = (x == 0) && (y == 0);
            m_bird = in_span(x, int'(pif.bird_x), BIRD_W) && in_span(y, int'(pif.bird_y), BIRD_H);
            m_gnd  = (y >= GROUND_Y) && (y < SCREEN_H);
            m_pipe = 0;
            for (int i = 0; i < NP; i++) begin
                px = int'(pif.pipe_x[10*i +: 10]);
                gy = int'(pif.pipe_gap_y[10*i +: 10]);
                if (pif.pipe_en[i] && in_span(x, px, PIPE_W) &&
                    ((y < gy) || (y >= gy + GAP_H && y < SCREEN_H)))
                    m_pipe = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rgb_now();
        return {pif.red, pif.green, pif.blue};
    endfunction

    task automatic step();
        @(posedge clk_div);
        #1;
        model_tick();
        chk("model_rgb", rgb_now(), m_rgb);
        chk("model_collision", {11'd0, pif.collision}, {11'd0, m_coll});
        chk("model_frame_pulse", {11'd0, pif.frame_pulse}, {11'd0, m_fp});
    endtask

    task automatic pix(int x, int y, bit vid);
        pif.pixel_x  = 10'(x);
        pif.pixel_y  = 10'(y);
        pif.video_on = vid;
    endtask

    task automatic bird(int x, int y);
        pif.bird_x = 10'(x);
        pif.bird_y = 10'(y);
    endtask

    task automatic set_pipe(int i, int x, int gy);
        pif.pipe_x[10*i +: 10]     = 10'(x);
        pif.pipe_gap_y[10*i +: 10] = 10'(gy);
    endtask

    task automatic show(int x, int y, bit vid, string tag, logic [11:0] exp);
        pix(x, y, vid);
        step();
        step();
        chk(tag, rgb_now(), exp);
    endtask

    // Sof pixel, then move away so only one sof is seen; returns after the strobe cycle.
    task automatic frame_end();
        pix(0, 0, 1);
        step();
        pix(500, 300, 1);
        step();
    endtask

    // Bird sits on an enabled pipe every frame; bird colour follows the blink rule.
    task automatic flash_run(int n);
        logic [11:0] exp;
        for (int k = 0; k < n; k++) begin
            pix(305, 45, 1);
            step();
            step();
            exp = 12'hF00;
`ifdef COLLISION_FLASH_EN
            if (k >= 1 && (k % 16) >= 8) exp = 12'hFFF;
`endif
            chk("flash_bird", rgb_now(), exp);
            pix(0, 0, 1);
            step();
        end
    endtask

    initial begin
        int base, ch;
        pif.pipe_x = '0;
        pif.pipe_gap_y = '0;
        pif.pipe_en = '0;
        bird(100, 100);
        pix(100, 100, 1);

        // Reset and latency.
        start = 1'b1;
        step();
        chk("reset_rgb", rgb_now(), 12'h000);
        chk("reset_collision", {11'd0, pif.collision}, 12'h000);
        chk("reset_pulse", {11'd0, pif.frame_pulse}, 12'h000);
        step();
        chk("reset_rgb2", rgb_now(), 12'h000);
        start = 1'b0;
        step();
        chk("latency_early", rgb_now(), 12'h000);
        step();
        chk("latency_bird", rgb_now(), 12'hF00);

        // Pipe geometry.
        bird(600, 300);
        set_pipe(0, 200, 150);
        pif.pipe_en = 5'b00001;
        show(210, 149, 1, "pipe_y149", 12'h0F0);
        show(210, 150, 1, "pipe_y150", 12'h000);
        show(210, 229, 1, "pipe_y229", 12'h000);
        show(210, 230, 1, "pipe_y230", 12'h0F0);
        show(240, 149, 1, "pipe_right_edge", 12'h000);
        show(239, 149, 1, "pipe_last_col", 12'h0F0);

        // Priority and blanking; the first pixel leaves a collision in this frame.
        bird(200, 90);
        show(210, 100, 1, "prio_bird", 12'hF00);
        show(210, 100, 0, "blank", 12'h000);
        show(500, 445, 1, "ground", 12'h840);
        show(500, 480, 1, "below_screen", 12'h000);

        frame_end();
        chk("sof_pulse", {11'd0, pif.frame_pulse}, 12'h001);
        chk("sof_collision", {11'd0, pif.collision}, 12'h001);
        step();
        chk("pulse_one_cycle", {11'd0, pif.frame_pulse}, 12'h000);
        chk("collision_held", {11'd0, pif.collision}, 12'h001);
        show(500, 300, 1, "quiet_frame", 12'h000);
        frame_end();
        chk("clean_frame_collision", {11'd0, pif.collision}, 12'h000);

        // Channel mask and a pipe hanging off the right edge.
        set_pipe(0, 200, 100);
        set_pipe(1, 600, 100);
        set_pipe(2, 300, 100);
        set_pipe(3, 700, 100);
        set_pipe(4, 1010, 100);
        pif.pipe_en = 5'b10100;
        bird(200, 40);
        show(310, 50, 1, "ch2_on", 12'h0F0);
        show(610, 50, 1, "ch1_off", 12'h000);
        show(710, 50, 1, "ch3_off", 12'h000);
        show(1015, 50, 1, "ch4_wide", 12'h0F0);
        show(5, 50, 1, "no_wrap", 12'h000);
        show(205, 45, 1, "bird_on_disabled", 12'hF00);
        frame_end();
        chk("masked_collision", {11'd0, pif.collision}, 12'h000);

        // Hit on the sof pixel belongs to the ending frame.
        bird(0, 0);
        set_pipe(0, 0, 100);
        pif.pipe_en = 5'b00001;
        frame_end();
        chk("sof_pixel_hit", {11'd0, pif.collision}, 12'h001);
        bird(600, 300);
        frame_end();
        chk("sof_hit_cleared", {11'd0, pif.collision}, 12'h000);

        // Reset mid-frame discards the accumulated hit.
        set_pipe(2, 300, 100);
        pif.pipe_en = 5'b00100;
        bird(300, 40);
        show(305, 45, 1, "bird_on_pipe", 12'hF00);
        start = 1'b1;
        step();
        start = 1'b0;
        frame_end();
        chk("reset_mid_frame", {11'd0, pif.collision}, 12'h000);

        // Collision blink, then restart to confirm the frame counter clears.
        start = 1'b1;
        step();
        start = 1'b0;
        flash_run(34);
        start = 1'b1;
        step();
        start = 1'b0;
        flash_run(4);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                bird($urandom_range(0, 1023), $urandom_range(0, 500));
                for (int i = 0; i < NP; i++)
                    set_pipe(i, $urandom_range(0, 1023), $urandom_range(0, 480));
            end
            if ($urandom_range(0, 7) == 0) pif.pipe_en = NP'($urandom);
            start = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) begin
                pix(0, 0, $urandom_range(0, 3) != 0);
            end else begin
                ch = $urandom_range(0, NP);
                base = (ch == NP) ? int'(pif.bird_x) : int'(pif.pipe_x[10*ch +: 10]);
                pix((base + $urandom_range(0, 60) - 10) & 1023,
                    $urandom_range(0, 511), $urandom_range(0, 7) != 0);
            end
            step();
        end
        start = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
